// File: rtl/find_ones_pkg.sv
// rtl/find_ones_pkg.sv - shared types for the multi-lane set-bit scanner
package find_ones_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } fo_state_e;

    typedef enum logic {
        ORDER_ASC  = 1'b0,
        ORDER_DESC = 1'b1
    } scan_order_e;

endpackage

// File: rtl/find_ones_lane_pick.sv
// rtl/find_ones_lane_pick.sv - picks the first LANES set bits of a vector in scan order
module find_ones_lane_pick
    import find_ones_pkg::*;
#(
    parameter int N     = 16,
    parameter int LANES = 2,
    parameter int LOGN  = $clog2(N)
) (
    input  logic [N-1:0]          vec_i,
    input  scan_order_e           order_i,
    output logic [LANES*LOGN-1:0] pos_o,
    output logic [LANES-1:0]      lane_valid_o,
    output logic [N-1:0]          mask_o
);

    logic [N-1:0] left;
    logic         found;
    int           idx;

    // Each lane takes the first remaining set bit, then removes it for the next lane.
    always_comb begin
        left         = vec_i;
        pos_o        = '0;
        lane_valid_o = '0;
        mask_o       = '0;
        found        = 1'b0;
        idx          = 0;
        for (int l = 0; l < LANES; l++) begin
            found = 1'b0;
            idx   = 0;
            for (int b = 0; b < N; b++) begin
                if (!found) begin
                    idx = (order_i == ORDER_DESC) ? (N - 1 - b) : b;
                    if (left[idx]) begin
                        found = 1'b1;
                    end
                end
            end
            if (found) begin
                left[idx]                = 1'b0;
                mask_o[idx]              = 1'b1;
                lane_valid_o[l]          = 1'b1;
                pos_o[l*LOGN +: LOGN]    = LOGN'(idx);
            end
        end
    end

endmodule

// File: rtl/find_ones_multilane.sv
// rtl/find_ones_multilane.sv - emits set-bit positions of a vector, LANES per beat
module find_ones_multilane
    import find_ones_pkg::*;
#(
    parameter int N     = 16,
    parameter int LANES = 2,
    localparam int LOGN = $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [N-1:0]          data_i,
    input  logic                  msb_first_i,
    input  logic                  abort_i,
    output logic                  ready_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*LOGN-1:0] out_pos_o,
    output logic [LANES-1:0]      out_lane_valid_o,
    output logic                  out_last_o,
    output logic [LOGN:0]         count_o,
    output logic                  done_o,
    output logic                  empty_o
);

    fo_state_e             state_q, state_d;
    scan_order_e           order_q, order_d;
    logic [N-1:0]          rem_q, rem_d;
    logic [LANES*LOGN-1:0] pos_q, pos_d;
    logic [LANES-1:0]      lv_q, lv_d;
    logic                  last_q, last_d;
    logic [LOGN:0]         count_q, count_d;
    logic                  empty_q, empty_d;

    logic [N-1:0]          pick_vec;
    scan_order_e           pick_order;
    logic [LANES*LOGN-1:0] pick_pos;
    logic [LANES-1:0]      pick_lv;
    logic [N-1:0]          pick_mask;
    logic [N-1:0]          pick_left;
    logic [LOGN:0]         pop;

    find_ones_lane_pick #(.N(N), .LANES(LANES), .LOGN(LOGN)) u_pick (
        .vec_i        (pick_vec),
        .order_i      (pick_order),
        .pos_o        (pick_pos),
        .lane_valid_o (pick_lv),
        .mask_o       (pick_mask)
    );

    assign pick_left = pick_vec & ~pick_mask;

    always_comb begin
        pop = '0;
        for (int b = 0; b < N; b++) begin
            pop = pop + (LOGN+1)'(data_i[b]);
        end
    end

    // rem_q holds only the bits not yet presented, so out_last is known when a beat is loaded.
    always_comb begin
        state_d    = state_q;
        order_d    = order_q;
        rem_d      = rem_q;
        pos_d      = pos_q;
        lv_d       = lv_q;
        last_d     = last_q;
        count_d    = count_q;
        empty_d    = empty_q;
        pick_vec   = rem_q;
        pick_order = order_q;
        case (state_q)
            ST_IDLE: begin
                pick_vec   = data_i;
                pick_order = scan_order_e'(msb_first_i);
                if (start_i) begin
                    order_d = scan_order_e'(msb_first_i);
                    count_d = pop;
                    empty_d = (data_i == '0);
                    rem_d   = pick_left;
                    pos_d   = pick_pos;
                    lv_d    = pick_lv;
                    last_d  = (data_i != '0) && (pick_left == '0);
                    state_d = (data_i == '0) ? ST_FINISH : ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (abort_i || (out_ready_i && last_q)) begin
                    rem_d   = '0;
                    pos_d   = '0;
                    lv_d    = '0;
                    last_d  = 1'b0;
                    state_d = abort_i ? ST_IDLE : ST_FINISH;
                end else if (out_ready_i) begin
                    rem_d  = pick_left;
                    pos_d  = pick_pos;
                    lv_d   = pick_lv;
                    last_d = (pick_left == '0);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            order_q <= ORDER_ASC;
            rem_q   <= '0;
            pos_q   <= '0;
            lv_q    <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            lv_q    <= lv_d;
            last_q  <= last_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    assign ready_o          = (state_q == ST_IDLE);
    assign out_valid_o      = (state_q == ST_EMIT);
    assign out_pos_o        = pos_q;
    assign out_lane_valid_o = lv_q;
    assign out_last_o       = last_q;
    assign count_o          = count_q;
    assign empty_o          = empty_q;
    assign done_o           = (state_q == ST_FINISH) && !abort_i;

endmodule

// File: tb/tb_find_ones_multilane.sv
// tb/tb_find_ones_multilane.sv - directed self-checking bench for find_ones_multilane
module tb_find_ones_multilane;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic        msb_first = 1'b0;
    logic        abort = 1'b0;
    logic        ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_pos;
    logic [1:0]  out_lv;
    logic        out_last;
    logic [4:0]  count;
    logic        done;
    logic        empty;

    int compared   = 0;
    int mismatched = 0;

    find_ones_multilane #(.N(16), .LANES(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .data_i           (data),
        .msb_first_i      (msb_first),
        .abort_i          (abort),
        .ready_o          (ready),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pos_o        (out_pos),
        .out_lane_valid_o (out_lv),
        .out_last_o       (out_last),
        .count_o          (count),
        .done_o           (done),
        .empty_o          (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [3:0] p0, input logic [3:0] p1,
                        input logic [1:0] lv, input logic last);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".pos"},   32'(out_pos),   32'({p1, p0}));
        chk({tag, ".lv"},    32'(out_lv),    32'(lv));
        chk({tag, ".last"},  32'(out_last),  32'(last));
    endtask

    task automatic idle_after(input string tag);
        chk({tag, ".ready"}, 32'(ready),     32'd1);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".done"},  32'(done),      32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst.ready", 32'(ready),     32'd1);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.pos",   32'(out_pos),   32'd0);
        chk("rst.lv",    32'(out_lv),    32'd0);
        chk("rst.last",  32'(out_last),  32'd0);
        chk("rst.done",  32'(done),      32'd0);
        chk("rst.count", 32'(count),     32'd0);
        chk("rst.empty", 32'(empty),     32'd0);
        rst = 1'b0;
        step();

        // zero vector: straight to FINISH
        start = 1'b1; data = 16'h0000; msb_first = 1'b0;
        step();
        start = 1'b0;
        chk("zero.done",  32'(done),      32'd1);
        chk("zero.valid", 32'(out_valid), 32'd0);
        chk("zero.empty", 32'(empty),     32'd1);
        chk("zero.count", 32'(count),     32'd0);
        step();
        idle_after("zero.after");

        // single bit
        start = 1'b1; data = 16'h0001;
        step();
        start = 1'b0;
        beat("one.b1", 4'd0, 4'd0, 2'b01, 1'b1);
        chk("one.count", 32'(count), 32'd1);
        chk("one.empty", 32'(empty), 32'd0);
        step();
        chk("one.done", 32'(done), 32'd1);
        step();
        idle_after("one.after");

        // 0x8421 ascending
        start = 1'b1; data = 16'h8421; msb_first = 1'b0;
        step();
        start = 1'b0;
        beat("asc.b1", 4'd0, 4'd5, 2'b11, 1'b0);
        chk("asc.count", 32'(count), 32'd4);
        step();
        beat("asc.b2", 4'd10, 4'd15, 2'b11, 1'b1);
        step();
        chk("asc.done", 32'(done), 32'd1);
        step();
        idle_after("asc.after");

        // 0x8421 descending
        start = 1'b1; data = 16'h8421; msb_first = 1'b1;
        step();
        start = 1'b0;
        beat("desc.b1", 4'd15, 4'd10, 2'b11, 1'b0);
        step();
        beat("desc.b2", 4'd5, 4'd0, 2'b11, 1'b1);
        step();
        chk("desc.done", 32'(done), 32'd1);
        step();
        idle_after("desc.after");

        // 0xFFFF with consumer stalling every other cycle
        start = 1'b1; data = 16'hFFFF; msb_first = 1'b0; out_ready = 1'b0;
        step();
        start = 1'b0;
        chk("full.count", 32'(count), 32'd16);
        for (int k = 0; k < 8; k++) begin
            beat($sformatf("full.b%0d", k), 4'(2*k), 4'(2*k+1), 2'b11, k == 7);
            step();
            beat($sformatf("full.stall%0d", k), 4'(2*k), 4'(2*k+1), 2'b11, k == 7);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("full.done", 32'(done), 32'd1);
        out_ready = 1'b1;
        step();
        idle_after("full.after");

        // abort on beat 2
        start = 1'b1; data = 16'h00FF;
        step();
        start = 1'b0;
        beat("abt.b1", 4'd0, 4'd1, 2'b11, 1'b0);
        step();
        beat("abt.b2", 4'd2, 4'd3, 2'b11, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        idle_after("abt.next");
        chk("abt.count", 32'(count), 32'd8);
        chk("abt.empty", 32'(empty), 32'd0);
        step();
        chk("abt.nodone", 32'(done), 32'd0);

        // reset mid-scan
        start = 1'b1; data = 16'h00FF;
        step();
        start = 1'b0;
        beat("rmid.b1", 4'd0, 4'd1, 2'b11, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        idle_after("rmid.async");
        chk("rmid.lv", 32'(out_lv), 32'd0);
        step();
        rst = 1'b0;
        step();
        idle_after("rmid.after");

        // recovery scan
        start = 1'b1; data = 16'h0003; msb_first = 1'b0;
        step();
        start = 1'b0;
        beat("rec.b1", 4'd0, 4'd1, 2'b11, 1'b1);
        chk("rec.count", 32'(count), 32'd2);
        step();
        chk("rec.done", 32'(done), 32'd1);
        step();
        idle_after("rec.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/find_ones_multilane.md
FIND_ONES_MULTILANE -- requirements
Module: find_ones_multilane

Interface
REQ-001 Parameter N, default 16, input vector width, N >= 2.
REQ-002 Parameter LANES, default 2, max positions emitted per beat, 1 <= LANES <= N.
REQ-003 Localparam LOGN = $clog2(N); count width is LOGN+1.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 start_i  input  1  request to scan data_i; accepted only when ready_o=1.
REQ-007 data_i  input  N  vector to scan; sampled on accepted start.
REQ-008 msb_first_i  input  1  scan order, sampled on accepted start: 0 = ascending index, 1 = descending.
REQ-009 abort_i  input  1  cancel the current scan.
REQ-010 ready_o  output  1  high in IDLE only.
REQ-011 out_valid_o  output  1  beat valid.
REQ-012 out_ready_i  input  1  consumer accepts the beat; handshake fires when out_valid_o & out_ready_i.
REQ-013 out_pos_o  output  LANES x LOGN  positions, lane 0 first in scan order.
REQ-014 out_lane_valid_o  output  LANES  per-lane valid; always contiguous from lane 0.
REQ-015 out_last_o  output  1  marks the final beat of a scan.
REQ-016 count_o  output  LOGN+1  popcount of the accepted vector.
REQ-017 done_o  output  1  single-cycle completion pulse.
REQ-018 empty_o  output  1  last completed scan found no ones.

Function
REQ-019 FSM states: IDLE, EMIT, FINISH.
REQ-020 IDLE & start_i: capture data_i into a remaining-vector register; capture msb_first_i; go to EMIT or FINISH.
REQ-021 EMIT: present up to LANES positions of the lowest (or highest, per captured mode) set bits of the remaining vector.
REQ-022 On handshake, clear the presented bits; the next beat appears in the following cycle with no bubble.
REQ-023 Beat payload (out_pos_o, out_lane_valid_o, out_last_o) is registered and held stable while out_valid_o=1 and out_ready_i=0.
REQ-024 out_last_o=1 iff the remaining vector is zero after this beat's bits are cleared.
REQ-025 Beats per scan = ceil(popcount/LANES); a scan of start at cycle t gives its first out_valid_o at t+1.
REQ-026 Handshake on the last beat -> FINISH; in FINISH assert done_o for one cycle, then return to IDLE.
REQ-027 Zero vector: no beats; FINISH at t+1 with done_o=1, empty_o=1, count_o=0.
REQ-028 count_o and empty_o are updated on the accepted start (count_o = popcount(data_i)) and hold until the next accepted start.
REQ-029 start_i outside IDLE is ignored.
REQ-030 abort_i in EMIT or FINISH: next cycle IDLE, out_valid_o=0, no done_o; count_o and empty_o are held.
REQ-031 abort_i in IDLE has no effect; if start_i and abort_i are both high in IDLE, start wins.
REQ-032 Lanes with out_lane_valid_o=0 drive position 0.

Reset
REQ-033 While rst_i=1: state=IDLE, ready_o=1, out_valid_o=0, out_lane_valid_o=0, out_pos_o=0, out_last_o=0, done_o=0, count_o=0, empty_o=0, remaining vector=0.
REQ-034 Reset asserted mid-scan discards the scan immediately; no done_o is produced.

Structure
REQ-035 Package find_ones_pkg holds the FSM state enum and the scan-order typedef.
REQ-036 One combinational sub-module, find_ones_lane_pick, takes the vector and scan order and returns LANES positions, lane valids and the cleared-vector mask.

Verification
REQ-037 Bench covers these scenarios (N=16, LANES=2):
- 0x0000 start -> no beats; done_o at t+1; empty_o=1; count_o=0.
- 0x0001, ascending, ready=1 -> one beat: pos {0,0}, lane_valid 01, last=1; count_o=1; empty_o=0.
- 0x8421, ascending, ready=1 -> beats {0,5} then {10,15}; last on beat 2; done_o one cycle later; count_o=4.
- 0x8421, descending -> beats {15,10} then {5,0}.
- 0xFFFF, out_ready_i toggling 1010... -> 8 beats in order {0,1}..{14,15}; payload stable during stalls; count_o=16.
- 0x00FF, abort_i on beat 2, then a separate run with rst_i mid-scan -> both: IDLE next cycle, out_valid_o=0, no done_o; a subsequent 0x0003 scan gives {0,1}, last=1.
